eng_data_router: RTL and testbench

ENG_DATA_ROUTER -- requirements
Module: eng_data_router

---
 rtl/eng_data_router_pkg.sv | 39 +++
 rtl/eng_data_router_if.sv | 46 ++++
 rtl/eng_dest_tracker.sv | 124 ++++++++++++
 rtl/eng_data_router.sv | 65 ++++++
 tb/tb_eng_data_router.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eng_data_router_pkg.sv
// ============================================================================
// eng_data_router_pkg : shared types and helpers for the engine data router
// Rev 1.0
// ============================================================================
`default_nettype none

package eng_data_router_pkg;

  localparam int C_TYPES_PER_CHNL = 3;
  localparam int C_WORD_BITS      = 32;

  typedef enum logic [1:0] {
    DEST_MAIN  = 2'd0,
    DEST_SG_RX = 2'd1,
    DEST_SG_TX = 2'd2
  } dest_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } dest_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int encode_tag(input int chnl, input dest_type_e dtype);
    return chnl * C_TYPES_PER_CHNL + int'(dtype);
  endfunction

endpackage

`default_nettype wire

// File: rtl/eng_data_router_if.sv
// ============================================================================
// eng_data_router_if : engine input, open handshake and routed output bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface eng_data_router_if
  import eng_data_router_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_NUM_CHNL   = 4
);
  localparam int C_NUM_DEST        = C_TYPES_PER_CHNL * C_NUM_CHNL;
  localparam int C_DATA_WORD_WIDTH = clog2(C_DATA_WIDTH / C_WORD_BITS + 1);
  localparam int C_TAG_WIDTH       = clog2(C_NUM_DEST);

  logic [C_DATA_WIDTH-1:0]                 eng_data;
  logic [C_DATA_WORD_WIDTH-1:0]            eng_data_en;
  logic [C_TAG_WIDTH-1:0]                  eng_tag;
  logic                                    eng_done;
  logic                                    eng_err;
  logic                                    open;
  logic [C_TAG_WIDTH-1:0]                  open_tag;
  logic [31:0]                             open_len;
  logic                                    open_ack;
  logic [C_DATA_WIDTH-1:0]                 out_data;
  logic [C_NUM_DEST*C_DATA_WORD_WIDTH-1:0] out_data_en;
  logic [C_NUM_DEST-1:0]                   out_done;
  logic [C_NUM_DEST-1:0]                   out_err;
  logic [C_NUM_DEST-1:0]                   busy;

  modport master (
    output eng_data, eng_data_en, eng_tag, eng_done, eng_err,
    output open, open_tag, open_len,
    input  open_ack, out_data, out_data_en, out_done, out_err, busy
  );

  modport slave (
    input  eng_data, eng_data_en, eng_tag, eng_done, eng_err,
    input  open, open_tag, open_len,
    output open_ack, out_data, out_data_en, out_done, out_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/eng_dest_tracker.sv
// ============================================================================
// eng_dest_tracker : per-destination IDLE/ACTIVE/FLUSH FSM with word counter
// Rev 1.0
// ============================================================================
`default_nettype none

module eng_dest_tracker
  import eng_data_router_pkg::*;
#(
  parameter int C_DATA_WORD_WIDTH = 3
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         open_hit,
  input  wire logic [31:0]                  open_len,
  input  wire logic                         eng_hit,
  input  wire logic [C_DATA_WORD_WIDTH-1:0] eng_data_en,
  input  wire logic                         eng_done,
  input  wire logic                         eng_err,
  output logic                              open_ack,
  output logic [C_DATA_WORD_WIDTH-1:0]      data_en,
  output logic                              done,
  output logic                              err,
  output logic                              busy
);

  dest_state_e                  r_state;
  dest_state_e                  w_state_nxt;
  logic [31:0]                  r_remain;
  logic [31:0]                  w_remain_nxt;
  logic [31:0]                  w_remain_eff;
  logic [31:0]                  w_eng_len;
  logic                         w_opening;
  logic [C_DATA_WORD_WIDTH-1:0] r_data_en;
  logic [C_DATA_WORD_WIDTH-1:0] w_data_en_nxt;
  logic                         r_done;
  logic                         w_done_nxt;
  logic                         r_err;
  logic                         w_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  // An open seen while IDLE takes effect first, so same-cycle data counts
  // against the freshly loaded length.
  always_comb begin
    w_state_nxt   = r_state;
    w_remain_nxt  = r_remain;
    w_data_en_nxt = '0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_opening     = open_hit && (r_state == ST_IDLE);
    w_remain_eff  = w_opening ? open_len : r_remain;
    w_eng_len     = 32'(eng_data_en);

    case (r_state)
      ST_FLUSH: begin
        if (eng_hit && eng_done) w_state_nxt = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        if ((r_state == ST_ACTIVE) || w_opening) begin
          w_state_nxt  = ST_ACTIVE;
          w_remain_nxt = w_remain_eff;
          if (eng_hit && (w_eng_len > w_remain_eff)) begin
            w_data_en_nxt = w_remain_eff[C_DATA_WORD_WIDTH-1:0];
            w_done_nxt    = 1'b1;
            w_err_nxt     = 1'b1;
            w_remain_nxt  = '0;
            w_state_nxt   = ST_IDLE;
          end else begin
            if (eng_hit) begin
              w_data_en_nxt = eng_data_en;
              w_remain_nxt  = w_remain_eff - w_eng_len;
            end
            if (eng_hit && eng_err) begin
              w_done_nxt   = 1'b1;
              w_err_nxt    = 1'b1;
              w_remain_nxt = '0;
              w_state_nxt  = eng_done ? ST_IDLE : ST_FLUSH;
            end else if ((w_remain_nxt == 32'd0) || (eng_hit && eng_done)) begin
              w_done_nxt   = 1'b1;
              w_remain_nxt = '0;
              w_state_nxt  = ST_IDLE;
            end
          end
        end else if (eng_hit && ((eng_data_en != '0) || eng_done || eng_err)) begin
          w_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_remain_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_en <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_data_en <= w_data_en_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign open_ack = w_opening;
  assign data_en  = r_data_en;
  assign done     = r_done;
  assign err      = r_err;
  assign busy     = (r_state == ST_ACTIVE);

endmodule

`default_nettype wire

// File: rtl/eng_data_router.sv
// ============================================================================
// eng_data_router : routes tagged engine data to per-destination trackers
// Rev 1.0
// ============================================================================
`default_nettype none

module eng_data_router
  import eng_data_router_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_NUM_CHNL   = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  eng_data_router_if.slave  bus
);

  localparam int C_NUM_DEST        = C_TYPES_PER_CHNL * C_NUM_CHNL;
  localparam int C_DATA_WORD_WIDTH = clog2(C_DATA_WIDTH / C_WORD_BITS + 1);
  localparam int C_TAG_WIDTH       = clog2(C_NUM_DEST);

  logic [C_DATA_WIDTH-1:0] r_out_data;
  logic [C_NUM_DEST-1:0]   w_open_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_data <= '0;
    else        r_out_data <= bus.eng_data;
  end

  assign bus.out_data = r_out_data;

  // Tags at or above C_NUM_DEST match no tracker and are dropped silently.
  generate
    for (genvar i = 0; i < C_NUM_DEST; i++) begin : g_dest
      logic w_open_hit;
      logic w_eng_hit;

      assign w_open_hit = bus.open && (bus.open_tag == C_TAG_WIDTH'(i));
      assign w_eng_hit  = (bus.eng_tag == C_TAG_WIDTH'(i));

      eng_dest_tracker #(
        .C_DATA_WORD_WIDTH (C_DATA_WORD_WIDTH)
      ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .open_hit    (w_open_hit),
        .open_len    (bus.open_len),
        .eng_hit     (w_eng_hit),
        .eng_data_en (bus.eng_data_en),
        .eng_done    (bus.eng_done),
        .eng_err     (bus.eng_err),
        .open_ack    (w_open_ack[i]),
        .data_en     (bus.out_data_en[i*C_DATA_WORD_WIDTH +: C_DATA_WORD_WIDTH]),
        .done        (bus.out_done[i]),
        .err         (bus.out_err[i]),
        .busy        (bus.busy[i])
      );
    end
  endgenerate

  assign bus.open_ack = rst_n & (|w_open_ack);

endmodule

`default_nettype wire

// File: tb/tb_eng_data_router.sv
// ============================================================================
// tb_eng_data_router : directed self-checking bench for eng_data_router
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_eng_data_router;
  import eng_data_router_pkg::*;

  localparam int DW = 512;
  localparam int NC = 12;
  localparam int D  = 36;
  localparam int W  = 5;
  localparam int TW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [DW-1:0] payload;

  eng_data_router_if #(.C_DATA_WIDTH(DW), .C_NUM_CHNL(NC)) bus ();

  eng_data_router #(.C_DATA_WIDTH(DW), .C_NUM_CHNL(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [D*W-1:0] en_vec(input int d, input int v);
    logic [D*W-1:0] r;
    r = '0;
    r[d*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [D-1:0] oh(input int d);
    logic [D-1:0] r;
    r = '0;
    r[d] = 1'b1;
    return r;
  endfunction

  function automatic int en_of(input int d);
    return int'(bus.out_data_en[d*W +: W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.eng_data_en = '0;
    bus.eng_tag     = '1;
    bus.eng_done    = 1'b0;
    bus.eng_err     = 1'b0;
    bus.open        = 1'b0;
    bus.open_tag    = '0;
    bus.open_len    = '0;
  endtask

  task automatic drive_open(input int tag, input int len);
    bus.open     = 1'b1;
    bus.open_tag = TW'(tag);
    bus.open_len = 32'(len);
  endtask

  task automatic drive_eng(input int tag, input int en, input logic dn, input logic er);
    bus.eng_tag     = TW'(tag);
    bus.eng_data_en = W'(en);
    bus.eng_done    = dn;
    bus.eng_err     = er;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.eng_data = {16{32'hA5C3_0F1E}};
    drive_open(1, 8);
    drive_eng(1, 4, 1'b0, 1'b0);
    repeat (2) tick();
    n_cmp++; if (bus.out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    n_cmp++; if (bus.out_data_en !== '0) begin n_bad++; $display("FAIL reset_out_data_en: got %h expected 0", bus.out_data_en); end
    n_cmp++; if ({bus.out_done, bus.out_err, bus.busy} !== '0) begin n_bad++; $display("FAIL reset_flags: got done=%h err=%h busy=%h expected 0", bus.out_done, bus.out_err, bus.busy); end
    n_cmp++; if (bus.open_ack !== 1'b0) begin n_bad++; $display("FAIL reset_open_ack: got %b expected 0", bus.open_ack); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive_open(1, 8);
    #1;
    n_cmp++; if (bus.open_ack !== 1'b1) begin n_bad++; $display("FAIL basic_ack: got %b expected 1", bus.open_ack); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.busy !== oh(1)) begin n_bad++; $display("FAIL basic_busy: got %h expected %h", bus.busy, oh(1)); end
    payload = {16{32'h1234_5678}};
    bus.eng_data = payload;
    drive_eng(1, 4, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.out_data_en !== en_vec(1, 4)) begin n_bad++; $display("FAIL basic_beat1_en: got %h expected %h", bus.out_data_en, en_vec(1, 4)); end
    n_cmp++; if (bus.out_data !== payload) begin n_bad++; $display("FAIL basic_beat1_data: got %h expected %h", bus.out_data, payload); end
    n_cmp++; if (bus.out_done !== '0) begin n_bad++; $display("FAIL basic_beat1_done: got %h expected 0", bus.out_done); end
    bus.eng_data = ~payload;
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_data_en !== en_vec(1, 4)) begin n_bad++; $display("FAIL basic_beat2_en: got %h expected %h", bus.out_data_en, en_vec(1, 4)); end
    n_cmp++; if (bus.out_done !== oh(1) || bus.out_err !== '0) begin n_bad++; $display("FAIL basic_done: got done=%h err=%h expected done=%h err=0", bus.out_done, bus.out_err, oh(1)); end
    n_cmp++; if (bus.busy !== '0) begin n_bad++; $display("FAIL basic_busy_drop: got %h expected 0", bus.busy); end
    tick();
    n_cmp++; if (bus.out_done !== '0) begin n_bad++; $display("FAIL basic_done_pulse: got %h expected 0", bus.out_done); end
  endtask

  task automatic test_overrun();
    drive_open(2, 6);
    tick();
    idle_inputs();
    drive_eng(2, 4, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.out_data_en !== en_vec(2, 4) || bus.out_done !== '0) begin n_bad++; $display("FAIL overrun_beat1: got en=%h done=%h expected en=%h done=0", bus.out_data_en, bus.out_done, en_vec(2, 4)); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_data_en !== en_vec(2, 2)) begin n_bad++; $display("FAIL overrun_trim: got %h expected %h", bus.out_data_en, en_vec(2, 2)); end
    n_cmp++; if (bus.out_done !== oh(2) || bus.out_err !== oh(2)) begin n_bad++; $display("FAIL overrun_pulses: got done=%h err=%h expected both %h", bus.out_done, bus.out_err, oh(2)); end
    n_cmp++; if (bus.busy !== '0) begin n_bad++; $display("FAIL overrun_busy: got %h expected 0", bus.busy); end
  endtask

  task automatic test_engine_error();
    drive_open(3, 16);
    tick();
    idle_inputs();
    drive_eng(3, 4, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.out_data_en !== en_vec(3, 4)) begin n_bad++; $display("FAIL eerr_beat_en: got %h expected %h", bus.out_data_en, en_vec(3, 4)); end
    drive_eng(3, 0, 1'b0, 1'b1);
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_done !== oh(3) || bus.out_err !== oh(3)) begin n_bad++; $display("FAIL eerr_pulses: got done=%h err=%h expected both %h", bus.out_done, bus.out_err, oh(3)); end
    n_cmp++; if (bus.busy !== '0) begin n_bad++; $display("FAIL eerr_busy: got %h expected 0", bus.busy); end
    drive_eng(3, 4, 1'b0, 1'b0);
    drive_open(3, 8);
    #1;
    n_cmp++; if (bus.open_ack !== 1'b0) begin n_bad++; $display("FAIL eerr_flush_ack: got %b expected 0", bus.open_ack); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_data_en !== '0 || bus.out_err !== '0 || bus.out_done !== '0) begin n_bad++; $display("FAIL eerr_flush_drop: got en=%h err=%h done=%h expected 0", bus.out_data_en, bus.out_err, bus.out_done); end
    drive_eng(3, 0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_done !== '0 || bus.out_err !== '0) begin n_bad++; $display("FAIL eerr_flush_end: got done=%h err=%h expected 0", bus.out_done, bus.out_err); end
    drive_open(3, 8);
    #1;
    n_cmp++; if (bus.open_ack !== 1'b1) begin n_bad++; $display("FAIL eerr_reopen_ack: got %b expected 1", bus.open_ack); end
    tick();
    idle_inputs();
    drive_eng(3, 0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_done !== oh(3) || bus.out_err !== '0) begin n_bad++; $display("FAIL eerr_short_done: got done=%h err=%h expected done=%h err=0", bus.out_done, bus.out_err, oh(3)); end
  endtask

  task automatic test_stray();
    drive_eng(5, 2, 1'b0, 1'b0);
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_data_en !== '0) begin n_bad++; $display("FAIL stray_en: got %h expected 0", bus.out_data_en); end
    n_cmp++; if (bus.out_err !== oh(5) || bus.out_done !== '0) begin n_bad++; $display("FAIL stray_err: got err=%h done=%h expected err=%h done=0", bus.out_err, bus.out_done, oh(5)); end
    tick();
    n_cmp++; if (bus.out_err !== '0) begin n_bad++; $display("FAIL stray_err_once: got %h expected 0", bus.out_err); end
    drive_open(1, 8);
    tick();
    #1;
    n_cmp++; if (bus.open_ack !== 1'b0) begin n_bad++; $display("FAIL busy_open_ack: got %b expected 0", bus.open_ack); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.busy !== oh(1)) begin n_bad++; $display("FAIL busy_kept: got %h expected %h", bus.busy, oh(1)); end
    drive_eng(1, 0, 1'b1, 1'b0);
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_done !== oh(1) || bus.out_err !== '0 || bus.busy !== '0) begin n_bad++; $display("FAIL short_done: got done=%h err=%h busy=%h expected done=%h", bus.out_done, bus.out_err, bus.busy, oh(1)); end
  endtask

  task automatic test_len_zero();
    drive_open(4, 0);
    #1;
    n_cmp++; if (bus.open_ack !== 1'b1) begin n_bad++; $display("FAIL len0_ack: got %b expected 1", bus.open_ack); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_done !== oh(4) || bus.out_err !== '0 || bus.busy !== '0) begin n_bad++; $display("FAIL len0_done: got done=%h err=%h busy=%h expected done=%h", bus.out_done, bus.out_err, bus.busy, oh(4)); end
  endtask

  task automatic test_bad_tag();
    drive_eng(40, 3, 1'b1, 1'b1);
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_data_en !== '0 || bus.out_err !== '0 || bus.out_done !== '0) begin n_bad++; $display("FAIL bad_tag: got en=%h err=%h done=%h expected 0", bus.out_data_en, bus.out_err, bus.out_done); end
  endtask

  task automatic test_same_cycle();
    drive_open(6, 4);
    drive_eng(6, 4, 1'b0, 1'b0);
    #1;
    n_cmp++; if (bus.open_ack !== 1'b1) begin n_bad++; $display("FAIL same_ack: got %b expected 1", bus.open_ack); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.out_data_en !== en_vec(6, 4) || bus.out_done !== oh(6) || bus.out_err !== '0 || bus.busy !== '0) begin n_bad++; $display("FAIL same_cycle: got en=%h done=%h err=%h busy=%h expected en=%h done=%h", bus.out_data_en, bus.out_done, bus.out_err, bus.busy, en_vec(6, 4), oh(6)); end
  endtask

  task automatic test_interleave();
    int tags[3];
    int lens[3];
    int rem[3];
    int got[3];
    int dn[3];
    int errs;
    int left;
    tags[0] = encode_tag(0, DEST_MAIN);
    tags[1] = encode_tag(5, DEST_SG_TX);
    tags[2] = encode_tag(11, DEST_SG_TX);
    lens[0] = 40; lens[1] = 23; lens[2] = 57;
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      rem[k] = lens[k]; got[k] = 0; dn[k] = 0;
      drive_open(tags[k], lens[k]);
      tick();
    end
    idle_inputs();
    for (int cyc = 0; cyc < 400 && (rem[0] + rem[1] + rem[2]) > 0; cyc++) begin
      int k;
      k = int'($urandom_range(0, 2));
      if (rem[k] > 0) begin
        int n;
        n = int'($urandom_range(1, (rem[k] < 16) ? rem[k] : 16));
        bus.eng_data = {16{$urandom}};
        drive_eng(tags[k], n, 1'b0, 1'b0);
        rem[k] -= n;
      end else begin
        idle_inputs();
      end
      tick();
      for (int j = 0; j < 3; j++) begin
        got[j] += en_of(tags[j]);
        dn[j]  += int'(bus.out_done[tags[j]]);
      end
      errs += int'(|bus.out_err);
    end
    idle_inputs();
    left = rem[0] + rem[1] + rem[2];
    n_cmp++; if (left !== 0) begin n_bad++; $display("FAIL ilv_timeout: got %0d words unsent expected 0", left); end
    for (int j = 0; j < 3; j++) begin
      n_cmp++; if (got[j] !== lens[j]) begin n_bad++; $display("FAIL ilv_total_tag%0d: got %0d expected %0d", tags[j], got[j], lens[j]); end
      n_cmp++; if (dn[j] !== 1) begin n_bad++; $display("FAIL ilv_done_tag%0d: got %0d expected 1", tags[j], dn[j]); end
    end
    n_cmp++; if (errs !== 0 || bus.busy !== '0) begin n_bad++; $display("FAIL ilv_clean: got errs=%0d busy=%h expected 0", errs, bus.busy); end
  endtask

  task automatic test_reset_mid();
    drive_open(7, 20);
    tick();
    idle_inputs();
    drive_eng(7, 4, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.out_data_en !== en_vec(7, 4) || bus.busy !== oh(7)) begin n_bad++; $display("FAIL rmid_pre: got en=%h busy=%h expected en=%h busy=%h", bus.out_data_en, bus.busy, en_vec(7, 4), oh(7)); end
    drive_open(8, 5);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_data !== '0 || bus.out_data_en !== '0 || bus.busy !== '0 || bus.open_ack !== 1'b0) begin n_bad++; $display("FAIL rmid_clear: got en=%h busy=%h ack=%b expected 0", bus.out_data_en, bus.busy, bus.open_ack); end
    repeat (2) tick();
    n_cmp++; if (bus.out_done !== '0 || bus.out_err !== '0) begin n_bad++; $display("FAIL rmid_pulses: got done=%h err=%h expected 0", bus.out_done, bus.out_err); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    drive_open(7, 3);
    #1;
    n_cmp++; if (bus.open_ack !== 1'b1) begin n_bad++; $display("FAIL rmid_reopen_ack: got %b expected 1", bus.open_ack); end
    tick();
    idle_inputs();
    n_cmp++; if (bus.busy !== oh(7) || bus.out_done !== '0 || bus.out_err !== '0) begin n_bad++; $display("FAIL rmid_resume: got busy=%h done=%h err=%h expected busy=%h", bus.busy, bus.out_done, bus.out_err, oh(7)); end
  endtask

  initial begin
    bus.eng_data = '0;
    idle_inputs();
    test_reset();
    test_basic();
    test_overrun();
    test_engine_error();
    test_stray();
    test_len_zero();
    test_bad_tag();
    test_same_cycle();
    test_interleave();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
